mul_final_add_round_stage: RTL and testbench

- Stage directly downstream of the multiplier's column-compression (Wallace) tree.
- Consumes the final sum/carry vector pair for the 24x24 significand product and resolves it with a 2-stage pipelined carry-propagate adder.
- Normalizes, rounds to nearest-even and packs a single-precision result with exception flags.
- Valid/ready handshake on both sides; sits between the compression tree and the FPU result mux.

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/mul_final_add_round_stage_if.sv | 40 ++++
 rtl/mul_round_pack.sv | 87 ++++++++
 rtl/mul_final_add_round_stage.sv | 121 ++++++++++++
 tb/tb_mul_final_add_round_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision definitions used by the FPU datapath units.
// Contents:
//   - IEEE-754 single field widths and bit positions
//   - exponent bias and the all-ones (infinity/NaN) exponent code
//   - significand and full product widths for the 24x24 multiplier
//   - packed single-precision struct and a field-packing helper
package fpu_pkg;

   localparam int SP_W        = 32;
   localparam int SP_EXP_W    = 8;
   localparam int SP_FRAC_W   = 23;
   localparam int SP_SIGN_POS = 31;
   localparam int SP_EXP_LSB  = 23;
   localparam int SP_FRAC_LSB = 0;

   localparam int EXP_BIAS    = 127;
   localparam int EXP_MAX     = 255;

   localparam int SP_MAN_W    = SP_FRAC_W + 1;
   localparam int SP_PROD_W   = 2 * SP_MAN_W;

   typedef struct packed {
      logic                 sign;
      logic [SP_EXP_W-1:0]  exp;
      logic [SP_FRAC_W-1:0] frac;
   } spFloat_t;

   function automatic spFloat_t packSp(input logic sign,
                                       input logic [SP_EXP_W-1:0] exp,
                                       input logic [SP_FRAC_W-1:0] frac);
      spFloat_t f;
      f.sign = sign;
      f.exp  = exp;
      f.frac = frac;
      return f;
   endfunction

endpackage

// File: rtl/mul_final_add_round_stage_if.sv
// Bus bundle for the multiplier final-add/round stage.
// Upstream side : InValid/InReady handshake carrying SumVec, CarryVec,
//                 ExpIn (signed), SignIn, ZeroIn.
// Downstream side: OutValid/OutReady handshake carrying Result, Overflow,
//                 Underflow.
// master: the environment (drives operands and OutReady).
// slave : the stage itself.
interface mul_final_add_round_stage_if
   import fpu_pkg::*;
#(
   parameter int MAN_W = 24,
   parameter int EXP_W = 10
);
   localparam int PW = 2 * MAN_W;

   logic                    InValid;
   logic                    InReady;
   logic [PW-1:0]           SumVec;
   logic [PW-1:0]           CarryVec;
   logic signed [EXP_W-1:0] ExpIn;
   logic                    SignIn;
   logic                    ZeroIn;

   logic                    OutValid;
   logic                    OutReady;
   logic [SP_W-1:0]         Result;
   logic                    Overflow;
   logic                    Underflow;

   modport master (
      output InValid, SumVec, CarryVec, ExpIn, SignIn, ZeroIn, OutReady,
      input  InReady, OutValid, Result, Overflow, Underflow
   );

   modport slave (
      input  InValid, SumVec, CarryVec, ExpIn, SignIn, ZeroIn, OutReady,
      output InReady, OutValid, Result, Overflow, Underflow
   );

endinterface

// File: rtl/mul_round_pack.sv
// Combinational normalize / round-to-nearest-even / pack for a resolved
// significand product.
// Ports:
//   prod      in  2*MAN_W  unsigned product, leading one at bit PW-1 or PW-2
//   expIn     in  EXP_W    signed biased exponent before normalization
//   sign      in  1        result sign
//   zero      in  1        an operand was zero
//   result    out 32       packed IEEE-754 single
//   overflow  out 1        result saturated to infinity
//   underflow out 1        result flushed to zero (no denormals)
module mul_round_pack
   import fpu_pkg::*;
#(
   parameter int MAN_W = 24,
   parameter int EXP_W = 10
) (
   input  logic [2*MAN_W-1:0]      prod,
   input  logic signed [EXP_W-1:0] expIn,
   input  logic                    sign,
   input  logic                    zero,
   output logic [SP_W-1:0]         result,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int PW = 2 * MAN_W;
   localparam int FW = MAN_W - 1;
   // Two spare bits so that normalize (+1) and rounding carry (+1) can never
   // wrap the signed exponent.
   localparam int EW = EXP_W + 2;

   localparam logic signed [EW-1:0] ONE_S     = EW'(1);
   localparam logic signed [EW-1:0] ZERO_S    = '0;
   localparam logic signed [EW-1:0] EXP_MAX_S = EW'(EXP_MAX);

   function automatic logic roundUp(input logic guard, input logic sticky,
                                    input logic lsb);
      return guard && (sticky || lsb);
   endfunction

   function automatic logic [FW:0] roundFrac(input logic [FW-1:0] frac,
                                             input logic up);
      return {1'b0, frac} + {{FW{1'b0}}, up};
   endfunction

   logic [FW-1:0]          frac;
   logic                   guard;
   logic                   sticky;
   logic [FW:0]            rounded;
   logic signed [EW-1:0]   expNorm;
   logic signed [EW-1:0]   expFin;
   spFloat_t               res;

   always_comb begin
      // A product in [2,4) has its leading one at PW-1; otherwise shift by one.
      frac    = prod[PW-1] ? prod[PW-2 -: FW]     : prod[PW-3 -: FW];
      guard   = prod[PW-1] ? prod[PW-2-FW]        : prod[PW-3-FW];
      sticky  = prod[PW-1] ? |prod[PW-3-FW:0]     : |prod[PW-4-FW:0];

      expNorm = EW'(expIn);
      if (prod[PW-1]) begin
         expNorm = expNorm + ONE_S;
      end

      // All-ones fraction rounding up carries out into the exponent; the
      // remaining fraction bits are already zero in that case.
      rounded = roundFrac(frac, roundUp(guard, sticky, frac[0]));
      expFin  = rounded[FW] ? (expNorm + ONE_S) : expNorm;

      res       = packSp(sign, expFin[SP_EXP_W-1:0], rounded[FW-1:0]);
      overflow  = 1'b0;
      underflow = 1'b0;

      if (zero) begin
         res = packSp(sign, '0, '0);
      end else if (expFin >= EXP_MAX_S) begin
         res      = packSp(sign, '1, '0);
         overflow = 1'b1;
      end else if (expFin <= ZERO_S) begin
         res       = packSp(sign, '0, '0);
         underflow = 1'b1;
      end

      result = res;
   end

endmodule

// File: rtl/mul_final_add_round_stage.sv
// Final carry-propagate add, normalize, round and pack for the 24x24
// significand multiplier. Sits between the Wallace tree and the FPU result
// mux. The PW-bit add is split at HALF: the low half is resolved in stage 1,
// the high half plus the registered low carry in stage 2, which then feeds
// the round/pack logic into the output register.
// Ports:
//   Clk    in  rising-edge clock
//   Reset  in  asynchronous active-high reset
//   bus    slave side of mul_final_add_round_stage_if:
//          InValid/InReady, SumVec, CarryVec, ExpIn, SignIn, ZeroIn in;
//          OutValid/OutReady, Result, Overflow, Underflow out.
// Latency 2 cycles, one item per cycle, full backpressure without bubbles.
module mul_final_add_round_stage
   import fpu_pkg::*;
#(
   parameter int MAN_W = 24,
   parameter int EXP_W = 10,
   parameter int HALF  = 24
) (
   input  logic                          Clk,
   input  logic                          Reset,
   mul_final_add_round_stage_if.slave    bus
);

   localparam int PW = 2 * MAN_W;
   localparam int HW = PW - HALF;

   logic                    vld_p1;
   logic [HALF-1:0]         lowSum_p1;
   logic                    lowCarry_p1;
   logic [HW-1:0]           sumHi_p1;
   logic [HW-1:0]           carryHi_p1;
   logic signed [EXP_W-1:0] exp_p1;
   logic                    sign_p1;
   logic                    zero_p1;

   logic                    vld_p2;
   logic [SP_W-1:0]         result_p2;
   logic                    ovf_p2;
   logic                    unf_p2;

   logic                    s1Adv;
   logic                    s2Adv;
   logic [HALF:0]           lowSum;
   logic [HW-1:0]           pHi;
   logic [PW-1:0]           prod;
   logic [SP_W-1:0]         packResult;
   logic                    packOvf;
   logic                    packUnf;

   // A stage may load when it is empty or its content moves on this cycle.
   assign s2Adv       = !vld_p2 || bus.OutReady;
   assign s1Adv       = !vld_p1 || s2Adv;
   assign bus.InReady = s1Adv;

   assign lowSum = {1'b0, bus.SumVec[HALF-1:0]} + {1'b0, bus.CarryVec[HALF-1:0]};

   // ---- stage 1: low-half add, carry the high halves forward ----
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         vld_p1      <= 1'b0;
         lowSum_p1   <= '0;
         lowCarry_p1 <= 1'b0;
         sumHi_p1    <= '0;
         carryHi_p1  <= '0;
         exp_p1      <= '0;
         sign_p1     <= 1'b0;
         zero_p1     <= 1'b0;
      end else if (s1Adv) begin
         vld_p1 <= bus.InValid;
         if (bus.InValid) begin
            lowSum_p1   <= lowSum[HALF-1:0];
            lowCarry_p1 <= lowSum[HALF];
            sumHi_p1    <= bus.SumVec[PW-1:HALF];
            carryHi_p1  <= bus.CarryVec[PW-1:HALF];
            exp_p1      <= bus.ExpIn;
            sign_p1     <= bus.SignIn;
            zero_p1     <= bus.ZeroIn;
         end
      end
   end

   // ---- stage 2: high-half add, normalize/round/pack into output register ----
   assign pHi  = sumHi_p1 + carryHi_p1 + {{(HW-1){1'b0}}, lowCarry_p1};
   assign prod = {pHi, lowSum_p1};

   mul_round_pack #(
      .MAN_W (MAN_W),
      .EXP_W (EXP_W)
   ) u_roundPack (
      .prod      (prod),
      .expIn     (exp_p1),
      .sign      (sign_p1),
      .zero      (zero_p1),
      .result    (packResult),
      .overflow  (packOvf),
      .underflow (packUnf)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         vld_p2    <= 1'b0;
         result_p2 <= '0;
         ovf_p2    <= 1'b0;
         unf_p2    <= 1'b0;
      end else if (s2Adv) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            result_p2 <= packResult;
            ovf_p2    <= packOvf;
            unf_p2    <= packUnf;
         end
      end
   end

   assign bus.OutValid  = vld_p2;
   assign bus.Result    = result_p2;
   assign bus.Overflow  = ovf_p2;
   assign bus.Underflow = unf_p2;

endmodule

// File: tb/tb_mul_final_add_round_stage.sv
// Scoreboard bench for mul_final_add_round_stage: the driver pushes the
// hand-computed expected response for every accepted input, a monitor on the
// falling edge compares whatever the stage presents against the queue head.
module tb_mul_final_add_round_stage;
   import fpu_pkg::*;

   localparam int MAN_W = 24;
   localparam int EXP_W = 10;
   localparam int PW    = 2 * MAN_W;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      bit          chkLat;
      int          inCyc;
      int          id;
   } expItem_t;

   logic Clk = 1'b0;
   logic Reset;

   always #5 Clk = ~Clk;

   mul_final_add_round_stage_if #(.MAN_W(MAN_W), .EXP_W(EXP_W)) bus ();

   mul_final_add_round_stage #(
      .MAN_W (MAN_W),
      .EXP_W (EXP_W),
      .HALF  (24)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int       checks = 0;
   int       passes = 0;
   int       cyc = 0;
   int       accCnt = 0;
   int       nextId = 0;
   bit       frontSeen = 1'b0;
   expItem_t sbQ[$];
   int       popCyc[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
   endtask

   initial forever begin
      @(posedge Clk);
      cyc++;
   end

   // Monitor: compare the presented output to the queue head; pop on transfer.
   initial forever begin
      @(negedge Clk);
      if (!Reset && bus.OutValid) begin
         if (sbQ.size() == 0) begin
            check("unexpected output", 64'(bus.Result), 64'hDEAD);
         end else begin
            check($sformatf("item%0d result", sbQ[0].id), 64'(bus.Result), 64'(sbQ[0].res));
            check($sformatf("item%0d flags", sbQ[0].id),
                  64'({bus.Overflow, bus.Underflow}), 64'({sbQ[0].ovf, sbQ[0].unf}));
            if (sbQ[0].chkLat && !frontSeen)
               check($sformatf("item%0d latency", sbQ[0].id), 64'(cyc - sbQ[0].inCyc), 64'd2);
            frontSeen = 1'b1;
            if (bus.OutReady) begin
               void'(sbQ.pop_front());
               popCyc.push_back(cyc);
               frontSeen = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [PW-1:0] sv, input logic [PW-1:0] cv,
                       input logic signed [EXP_W-1:0] ex, input logic sg, input logic zr,
                       input logic [31:0] res, input logic ovf, input logic unf,
                       input bit chkLat);
      expItem_t e;
      bit ok;
      e.res = res; e.ovf = ovf; e.unf = unf; e.chkLat = chkLat; e.id = nextId;
      nextId++;
      bus.SumVec = sv; bus.CarryVec = cv; bus.ExpIn = ex;
      bus.SignIn = sg; bus.ZeroIn = zr; bus.InValid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge Clk);
         if (bus.InReady) begin
            ok = 1'b1;
            e.inCyc = cyc;
            sbQ.push_back(e);
            accCnt++;
         end
         @(posedge Clk);
         #1;
      end
      if (!ok) check($sformatf("item%0d accept timeout", e.id), 64'd0, 64'd1);
      bus.InValid = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 100 && sbQ.size() != 0; i++) @(posedge Clk);
      #1;
      check(nm, 64'(sbQ.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int base;
      int accBase;
      Reset = 1'b1;
      bus.InValid = 1'b0; bus.SumVec = '0; bus.CarryVec = '0; bus.ExpIn = '0;
      bus.SignIn = 1'b0; bus.ZeroIn = 1'b0; bus.OutReady = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      check("reset OutValid", 64'(bus.OutValid), 64'd0);
      check("reset Result", 64'(bus.Result), 64'd0);
      check("reset flags", 64'({bus.Overflow, bus.Underflow}), 64'd0);
      Reset = 1'b0;
      #1;
      check("InReady after reset", 64'(bus.InReady), 64'd1);
      @(posedge Clk);
      #1;

      // Directed vectors, back to back, no backpressure.
      send(48'h400000000000, 48'h0, 10'sd127, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1);
      send(48'h8FFFFFFFFFFF, 48'h000000000001, 10'sd127, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0, 1'b1);
      send(48'h400000400000, 48'h0, 10'sd127, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1);
      send(48'h400000C00000, 48'h0, 10'sd127, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1);
      send(48'h400000600000, 48'h0, 10'sd127, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b1);
      send(48'h7FFFFF000000, 48'h000000C00000, 10'sd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1);
      send(48'h800000000000, 48'h0, 10'sd254, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1);
      send(48'h400000000000, 48'h0, 10'sd0, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
      send(48'h123456789ABC, 48'h0F0F0F0F0F0F, 10'sd300, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1);
      send(48'h400000000000, 48'h0, 10'sd127, 1'b1, 1'b0, 32'hBF800000, 1'b0, 1'b0, 1'b1);
      drain("directed drain");

      // Backpressure: four items against a stalled output for five cycles.
      @(posedge Clk);
      #1;
      bus.OutReady = 1'b0;
      base = popCyc.size();
      accBase = accCnt;
      fork
         begin
            send(48'h400000000000, 48'h0, 10'sd127, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0);
            send(48'h8FFFFFFFFFFF, 48'h000000000001, 10'sd127, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0, 1'b0);
            send(48'h400000C00000, 48'h0, 10'sd127, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b0);
            send(48'h400000000000, 48'h0, 10'sd127, 1'b1, 1'b0, 32'hBF800000, 1'b0, 1'b0, 1'b0);
         end
         begin
            repeat (5) @(posedge Clk);
            #1;
            check("InReady under stall", 64'(bus.InReady), 64'd0);
            check("accepted under stall", 64'(accCnt - accBase), 64'd2);
            bus.OutReady = 1'b1;
         end
      join
      drain("backpressure drain");
      check("backpressure pop count", 64'(popCyc.size() - base), 64'd4);
      if (popCyc.size() >= base + 4)
         check("backpressure pop span", 64'(popCyc[base+3] - popCyc[base]), 64'd3);

      // Reset with two items in flight.
      bus.OutReady = 1'b0;
      send(48'h400000000000, 48'h0, 10'sd127, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0);
      send(48'h800000000000, 48'h0, 10'sd254, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0);
      #2;
      Reset = 1'b1;
      #1;
      check("OutValid on mid-run reset", 64'(bus.OutValid), 64'd0);
      check("Result on mid-run reset", 64'(bus.Result), 64'd0);
      sbQ.delete();
      frontSeen = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      bus.OutReady = 1'b1;
      #1;
      check("InReady after mid-run reset", 64'(bus.InReady), 64'd1);
      send(48'h800000000000, 48'h0, 10'sd100, 1'b0, 1'b0, 32'h32800000, 1'b0, 1'b0, 1'b1);
      drain("post-reset drain");

      repeat (3) @(posedge Clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
